// File: rtl/sample_ram_pkg.sv
// Shared sizing helpers and FSM state type for the batch filter's circular sample RAM.
// RAM geometry is derived here so writer, filter and bench agree on it.
package sample_ram_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } wr_state_t;

  function automatic int down_result_depth(input int depth, input int dsr1, input int dsr2);
    return (depth + dsr1 * dsr2 - 1) / (dsr1 * dsr2);
  endfunction

  function automatic int seg_depth(input int depth, input int dsr1, input int dsr2);
    return down_result_depth(depth, dsr1, dsr2) * dsr2;
  endfunction

  function automatic int ram_depth(input int depth, input int dsr1, input int dsr2);
    return 4 * seg_depth(depth, dsr1, dsr2);
  endfunction

endpackage

// File: rtl/sample_ram_writer_packer.sv
// Gathers DSR1 consecutive N-bit samples into one RAM word, oldest sample in the low bits.
// The word and its strobe are combinational so the top can register them on the accepting edge.
module sample_packer #(
  parameter int N    = 3,
  parameter int DSR1 = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N-1:0]      i_in,
  input  logic              i_inValid,
  output logic [N*DSR1-1:0] o_word,
  output logic              o_wordReady
);

  localparam int CntW = (DSR1 > 1) ? $clog2(DSR1) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DSR1 - 1);

  logic [CntW-1:0]   r_cnt;
  logic [N*DSR1-1:0] r_part;

  assign o_wordReady = i_inValid && (r_cnt == LastCnt);

  // Newest sample bypasses the partial register so the full word is ready on its own cycle.
  always_comb begin
    o_word = r_part;
    o_word[N*(DSR1-1) +: N] = i_in;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_part <= '0;
    end else if (i_inValid) begin
      r_part[N*r_cnt +: N] <= i_in;
      r_cnt                <= o_wordReady ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sample_ram_writer.sv
// Write-side front end of the circular sample RAM: packs samples, drives the RAM write port,
// hands completed segments to the reader and stalls when the reader falls behind.
module sample_ram_writer
  import sample_ram_pkg::*;
#(
  parameter int N     = 3,
  parameter int depth = 220,
  parameter int DSR1  = 2,
  parameter int DSR2  = 6,
  localparam int DownResultDepth = down_result_depth(depth, DSR1, DSR2),
  localparam int SegDepth        = seg_depth(depth, DSR1, DSR2),
  localparam int RamDepth        = ram_depth(depth, DSR1, DSR2),
  localparam int AddrW           = $clog2(RamDepth),
  localparam int SampleWidth     = N * DSR1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           in,
  input  logic                   inValid,
  input  logic                   segRelease,
  output logic                   sampleClk,
  output logic                   sampleWrite,
  output logic [AddrW-1:0]       sampleAddrIn,
  output logic [SampleWidth-1:0] sampleDataIn,
  output logic                   segDone,
  output logic [1:0]             segIndex,
  output logic [2:0]             outstanding,
  output logic                   overflow,
  output wr_state_t              dbgState
);

  localparam int SegW = $clog2(SegDepth);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(RamDepth - 1);
  localparam logic [SegW-1:0]  LastOff  = SegW'(SegDepth - 1);

  logic [SampleWidth-1:0] w_word;
  logic                   w_wordReady;
  logic                   w_write;
  logic                   w_segDone;
  logic                   w_overflowEvt;
  logic [2:0]             w_outstandingNext;
  wr_state_t              r_state;
  wr_state_t              w_stateNext;

  logic [AddrW-1:0]       r_addr;
  logic [SegW-1:0]        r_segOff;
  logic [1:0]             r_seg;
  logic                   r_sampleWrite;
  logic                   r_sampleClk;
  logic [AddrW-1:0]       r_sampleAddr;
  logic [SampleWidth-1:0] r_sampleData;
  logic                   r_segLast;
  logic                   r_segDone;
  logic [1:0]             r_segIndex;
  logic [2:0]             r_outstanding;
  logic                   r_overflow;

  sample_packer #(.N(N), .DSR1(DSR1)) u_packer (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_in        (in),
    .i_inValid   (inValid),
    .o_word      (w_word),
    .o_wordReady (w_wordReady)
  );

  assign w_write   = w_wordReady && (r_state == FILL);
  // Handover is one cycle after the last word of a segment, aligned with its sampleClk rise.
  assign w_segDone = r_segLast;
  // Completing a segment while the reader still holds three means the next one is not free.
  assign w_overflowEvt = w_segDone && !segRelease && (r_outstanding == 3'd3);

  always_comb begin
    w_outstandingNext = r_outstanding;
    if (w_segDone && !segRelease) begin
      if (r_outstanding != 3'd3) w_outstandingNext = r_outstanding + 3'd1;
    end else if (segRelease && !w_segDone && (r_outstanding != 3'd0)) begin
      w_outstandingNext = r_outstanding - 3'd1;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      FILL:    if (w_overflowEvt) w_stateNext = STALL;
      STALL:   if (r_outstanding < 3'd3) w_stateNext = FILL;
      default: w_stateNext = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= FILL;
    else      r_state <= w_stateNext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr        <= '0;
      r_segOff      <= '0;
      r_seg         <= '0;
      r_sampleWrite <= 1'b0;
      r_sampleClk   <= 1'b0;
      r_sampleAddr  <= '0;
      r_sampleData  <= '0;
      r_segLast     <= 1'b0;
      r_segDone     <= 1'b0;
      r_segIndex    <= '0;
      r_outstanding <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_sampleWrite <= w_write;
      r_sampleClk   <= r_sampleWrite;
      r_segLast     <= w_write && (r_segOff == LastOff);
      r_segDone     <= w_segDone;
      r_outstanding <= w_outstandingNext;
      if (w_overflowEvt) r_overflow <= 1'b1;
      // r_seg has already stepped past the completed segment by now.
      if (w_segDone) r_segIndex <= r_seg - 2'd1;
      if (w_write) begin
        r_sampleAddr <= r_addr;
        r_sampleData <= w_word;
        r_addr       <= (r_addr == LastAddr) ? '0 : r_addr + 1'b1;
        if (r_segOff == LastOff) begin
          r_segOff <= '0;
          r_seg    <= r_seg + 2'd1;
        end else begin
          r_segOff <= r_segOff + 1'b1;
        end
      end
    end
  end

  assign sampleClk    = r_sampleClk;
  assign sampleWrite  = r_sampleWrite;
  assign sampleAddrIn = r_sampleAddr;
  assign sampleDataIn = r_sampleData;
  assign segDone      = r_segDone;
  assign segIndex     = r_segIndex;
  assign outstanding  = r_outstanding;
  assign overflow     = r_overflow;
  assign dbgState     = r_state;

endmodule

// File: tb/tb_sample_ram_writer.sv
// Bench for sample_ram_writer: hand-computed vector table, directed segment/overflow
// sequences and a random run, all scored against a sample-stream reference model.
module tb_sample_ram_writer;
  import sample_ram_pkg::*;

  localparam int N     = 3;
  localparam int DEPTH = 220;
  localparam int DSR1  = 2;
  localparam int DSR2  = 6;
  localparam int SEG   = seg_depth(DEPTH, DSR1, DSR2);
  localparam int RAM   = ram_depth(DEPTH, DSR1, DSR2);
  localparam int AW    = $clog2(RAM);
  localparam int SW    = N * DSR1;
  localparam int VW    = 2 + AW + SW + 1 + 2 + 3 + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]  tb_in;
  logic          inValid;
  logic          segRelease;
  logic          sampleClk;
  logic          sampleWrite;
  logic [AW-1:0] sampleAddrIn;
  logic [SW-1:0] sampleDataIn;
  logic          segDone;
  logic [1:0]    segIndex;
  logic [2:0]    outstanding;
  logic          overflow;
  wr_state_t     dbgState;

  sample_ram_writer #(.N(N), .depth(DEPTH), .DSR1(DSR1), .DSR2(DSR2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (tb_in),
    .inValid      (inValid),
    .segRelease   (segRelease),
    .sampleClk    (sampleClk),
    .sampleWrite  (sampleWrite),
    .sampleAddrIn (sampleAddrIn),
    .sampleDataIn (sampleDataIn),
    .segDone      (segDone),
    .segIndex     (segIndex),
    .outstanding  (outstanding),
    .overflow     (overflow),
    .dbgState     (dbgState)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes;
  bit chk_en;

  // reference model: sample stream, segment ownership and expected output image
  logic [N-1:0]       m_grp[$];
  int                 m_addr, m_out, m_done_seg;
  bit                 m_stall, m_done_pend;
  logic               e_wr, e_clk, e_done, e_ovf;
  logic [AW-1:0]      e_addr;
  logic [SW-1:0]      e_data;
  logic [1:0]         e_idx;
  logic [2:0]         e_out;
  logic [AW+SW-1:0]   exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_grp.delete();
    exp_q.delete();
    m_addr = 0; m_out = 0; m_done_seg = 0;
    m_stall = 0; m_done_pend = 0;
    e_wr = 0; e_clk = 0; e_done = 0; e_ovf = 0;
    e_addr = '0; e_data = '0; e_idx = '0; e_out = '0;
  endtask

  task automatic model_edge(input logic v, input logic [N-1:0] d, input logic rel);
    bit stall_now;
    int out_now;
    logic [SW-1:0] w;
    stall_now = m_stall;
    out_now   = m_out;
    e_clk  = e_wr;
    e_done = m_done_pend;
    if (m_done_pend) e_idx = 2'(m_done_seg);
    if (m_done_pend && !rel) begin
      if (out_now == 3) begin
        e_ovf   = 1'b1;
        m_stall = 1;
      end else begin
        m_out = out_now + 1;
      end
    end else if (!m_done_pend && rel && out_now > 0) begin
      m_out = out_now - 1;
    end
    if (stall_now && out_now < 3) m_stall = 0;
    e_out = 3'(m_out);
    e_wr = 1'b0;
    m_done_pend = 0;
    if (v) begin
      m_grp.push_back(d);
      if (m_grp.size() == DSR1) begin
        if (!stall_now) begin
          w = '0;
          for (int i = 0; i < DSR1; i++) w = w | (SW'(m_grp[i]) << (N * i));
          e_wr   = 1'b1;
          e_data = w;
          e_addr = AW'(m_addr);
          exp_q.push_back({e_addr, e_data});
          if ((m_addr + 1) % SEG == 0) begin
            m_done_pend = 1;
            m_done_seg  = m_addr / SEG;
          end
          m_addr = (m_addr + 1) % RAM;
        end
        m_grp.delete();
      end
    end
  endtask

  task automatic check_cycle();
    logic [VW-1:0] act_v, exp_v;
    logic [AW+SW-1:0] q;
    act_v = {sampleWrite, sampleClk, sampleAddrIn, sampleDataIn, segDone, segIndex, outstanding, overflow};
    exp_v = {e_wr, e_clk, e_addr, e_data, e_done, e_idx, e_out, e_ovf};
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle t=%0t: got %h want %h (wr,clk,addr,data,done,idx,out,ovf)", $time, act_v, exp_v);
    end
    if (sampleWrite === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_sb t=%0t: got addr %0d data %h want no write", $time, sampleAddrIn, sampleDataIn);
      end else begin
        q = exp_q.pop_front();
        if ({sampleAddrIn, sampleDataIn} !== q) begin
          n_fail++;
          $display("FAIL write_sb t=%0t: got %h want %h", $time, {sampleAddrIn, sampleDataIn}, q);
        end
      end
    end
  endtask

  // driver
  task automatic step(input logic v, input logic [N-1:0] d, input logic rel);
    inValid = v; tb_in = d; segRelease = rel;
    @(posedge clk);
    #1;
    model_edge(v, d, rel);
    if (chk_en) check_cycle();
    if (sampleWrite === 1'b1) n_writes++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    inValid = 1'b0; segRelease = 1'b0;
    #1 rst = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    n_writes = 0;
  endtask

  task automatic drain_check();
    check("sb_drained", exp_q.size(), 0);
  endtask

  typedef struct {
    logic          v;
    logic [N-1:0]  d;
    logic          rel;
    logic          wr;
    logic          sclk;
    logic [AW-1:0] addr;
    logic [SW-1:0] data;
    logic [2:0]    outst;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int stall_writes, first_addr;
    bit got;
    logic [1+1+AW+SW+3-1:0] tv_act, tv_exp;

    tbl[0]  = '{1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 9'd0, 6'b000_000, 3'd0};
    tbl[1]  = '{1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 9'd0, 6'b010_001, 3'd0};
    tbl[2]  = '{1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 9'd0, 6'b010_001, 3'd0};
    tbl[3]  = '{1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 9'd1, 6'b100_011, 3'd0};
    tbl[4]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 9'd1, 6'b100_011, 3'd0};
    tbl[5]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 9'd1, 6'b100_011, 3'd0};
    tbl[6]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 9'd1, 6'b100_011, 3'd0};
    tbl[7]  = '{1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 9'd1, 6'b100_011, 3'd0};
    tbl[8]  = '{1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 9'd1, 6'b100_011, 3'd0};
    tbl[9]  = '{1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 9'd2, 6'b110_101, 3'd0};
    tbl[10] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 9'd2, 6'b110_101, 3'd0};

    inValid = 1'b0; tb_in = '0; segRelease = 1'b0; chk_en = 0; n_writes = 0;
    model_reset();

    // asynchronous reset before any clock edge
    #2 rst = 1'b0;
    #1;
    check("rst_sampleClk", sampleClk, 0);
    check("rst_sampleWrite", sampleWrite, 0);
    check("rst_addr", sampleAddrIn, 0);
    check("rst_data", sampleDataIn, 0);
    check("rst_segDone", segDone, 0);
    check("rst_segIndex", segIndex, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", dbgState, FILL);
    @(negedge clk);
    rst = 1'b1;

    // half a group, then reset: the stray sample must not reach the RAM
    step(1'b1, 3'd7, 1'b0);
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].rel);
      tv_act = {sampleWrite, sampleClk, sampleAddrIn, sampleDataIn, outstanding};
      tv_exp = {tbl[i].wr, tbl[i].sclk, tbl[i].addr, tbl[i].data, tbl[i].outst};
      check($sformatf("tbl[%0d]", i), 32'(tv_act), 32'(tv_exp));
    end

    // continuous stream through all four segments and the address wrap
    do_reset();
    chk_en = 1;
    for (int c = 0; c < 920; c++) begin
      step(1'b1, 3'(c % 8), (c == 100) || (c == 456) || (c == 600) || (c == 684));
      if (c == 100) check("rel_at_zero", outstanding, 0);
      if (c == 226) check("seg0_not_yet", segDone, 0);
      if (c == 228) begin
        check("seg0_done", segDone, 1);
        check("seg0_index", segIndex, 0);
        check("seg0_outstanding", outstanding, 1);
        check("seg0_addr", sampleAddrIn, SEG - 1);
      end
      if (c == 456) begin
        check("seg1_index", segIndex, 1);
        check("coincident_outstanding", outstanding, 1);
      end
      if (c == 911) check("last_addr", sampleAddrIn, RAM - 1);
      if (c == 913) begin
        check("wrap_write", sampleWrite, 1);
        check("wrap_addr", sampleAddrIn, 0);
      end
    end
    check("contig_writes", n_writes, 460);
    drain_check();

    // no releases: fourth completion overflows, writes stop, resume at segment start
    do_reset();
    stall_writes = 0;
    for (int c = 0; c < 1000; c++) begin
      step(1'b1, 3'($urandom_range(0, 7)), 1'b0);
      if (c == 912) begin
        check("ovf_set", overflow, 1);
        check("ovf_state", dbgState, STALL);
        check("ovf_outstanding", outstanding, 3);
      end
      if (c > 912 && sampleWrite === 1'b1) stall_writes++;
    end
    check("stall_no_writes", stall_writes, 0);
    step(1'b0, 3'd0, 1'b1);
    check("release_outstanding", outstanding, 2);
    got = 0; first_addr = -1;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 3'($urandom_range(0, 7)), 1'b0);
      if (sampleWrite === 1'b1 && !got) begin
        got = 1;
        first_addr = int'(sampleAddrIn);
      end
    end
    check("resume_seen", got, 1);
    check("resume_addr", first_addr, 0);
    check("ovf_sticky", overflow, 1);
    check("resume_state", dbgState, FILL);
    drain_check();

    // gapped input: one word every four cycles
    do_reset();
    for (int c = 0; c < 120; c++) step(1'(c % 2 == 0), 3'((c / 2) % 8), 1'b0);
    check("gap_writes", n_writes, 30);
    check("gap_last_addr", sampleAddrIn, 29);
    drain_check();

    // random traffic with sparse releases
    do_reset();
    for (int c = 0; c < 6000; c++)
      step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 399) == 0));
    drain_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
